// File: rtl/fp_mul_seq_if.sv
// Request/result bundle for the sequential floating-point multiplier.
// W = 1 + EXP_W + MAN_W; widths must match the attached fp_mul_seq instance.
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] ans;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output start, a, b,
    input  busy, done, ans, overflow, underflow, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, ans, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier: shift-add significand product, then
// normalise, round (truncate or nearest-even) and pack with special-value handling.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ROUND = 0
) (
  input logic         clk,
  input logic         rst,
  fp_mul_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_RND  = 2'd3;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_NAN  = 2'd2;
  localparam logic [1:0] K_INF  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           kind;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic [EXP_W-1:0]     ea, eb;
  logic [PW-1:0]        mcand, prod;
  logic [SW-1:0]        mplr;
  logic signed [EW-1:0] e;
  logic [MAN_W-1:0]     frac;
  logic                 guard, sticky;

  logic                 a_emax, b_emax, a_ezero, b_ezero, a_mnz, b_mnz;
  logic [1:0]           kind_in;
  logic signed [EW-1:0] e_sum;
  logic                 inc;
  logic [MAN_W:0]       frac_inc;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         ans_n;
  logic                 ovf_n, unf_n, inv_n;

  assign bus.busy = (state != S_IDLE);

  // Special-operand classification, captured alongside the operands.
  always_comb begin
    a_emax  = &bus.a[W-2:MAN_W];
    b_emax  = &bus.b[W-2:MAN_W];
    a_ezero = ~|bus.a[W-2:MAN_W];
    b_ezero = ~|bus.b[W-2:MAN_W];
    a_mnz   = |bus.a[MAN_W-1:0];
    b_mnz   = |bus.b[MAN_W-1:0];
    kind_in = K_NONE;
    if ((a_emax & a_mnz) | (b_emax & b_mnz) | (a_emax & b_ezero) | (b_emax & a_ezero))
      kind_in = K_NAN;
    else if (a_emax | b_emax)
      kind_in = K_INF;
    else if (a_ezero | b_ezero)
      kind_in = K_ZERO;
  end

  always_comb begin
    e_sum    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    inc      = (ROUND == 1) && guard && (sticky || frac[0]);
    frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    // A rounding carry leaves the low fraction bits at zero already.
    e_r      = frac_inc[MAN_W] ? e + EW'(1) : e;
    ans_n    = '0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    inv_n    = 1'b0;
    case (kind)
      K_ZERO: ans_n = {sign, {(W-1){1'b0}}};
      K_NAN: begin
        ans_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        inv_n = 1'b1;
      end
      K_INF: ans_n = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default: begin
        if (e_r >= EMAX) begin
          ans_n = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_n = 1'b1;
        end else if (e_r <= 0) begin
          ans_n = {sign, {(W-1){1'b0}}};
          unf_n = 1'b1;
        end else begin
          ans_n = {sign, e_r[EXP_W-1:0], frac_inc[MAN_W-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      kind          <= K_NONE;
      cnt           <= '0;
      sign          <= 1'b0;
      ea            <= '0;
      eb            <= '0;
      mcand         <= '0;
      mplr          <= '0;
      prod          <= '0;
      e             <= '0;
      frac          <= '0;
      guard         <= 1'b0;
      sticky        <= 1'b0;
      bus.done      <= 1'b0;
      bus.ans       <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.invalid   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sign  <= bus.a[W-1] ^ bus.b[W-1];
            ea    <= bus.a[W-2:MAN_W];
            eb    <= bus.b[W-2:MAN_W];
            mcand <= {{SW{1'b0}}, 1'b1, bus.a[MAN_W-1:0]};
            mplr  <= {1'b1, bus.b[MAN_W-1:0]};
            prod  <= '0;
            kind  <= kind_in;
            cnt   <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplr[0]) prod <= prod + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(SW - 1)) state <= S_NORM;
        end
        S_NORM: begin
          if (prod[PW-1]) begin
            e      <= e_sum + EW'(1);
            frac   <= prod[PW-2 -: MAN_W];
            guard  <= prod[MAN_W];
            sticky <= |prod[MAN_W-1:0];
          end else begin
            e      <= e_sum;
            frac   <= prod[PW-3 -: MAN_W];
            guard  <= prod[MAN_W-1];
            sticky <= |prod[MAN_W-2:0];
          end
          state <= S_RND;
        end
        default: begin
          bus.ans       <= ans_n;
          bus.overflow  <= ovf_n;
          bus.underflow <= unf_n;
          bus.invalid   <= inv_n;
          bus.done      <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: single (truncate and RNE) and half precision instances
// checked every cycle against an arithmetic reference model and scoreboard.
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int LAT0 = 26;
  localparam int LAT2 = 13;

  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus0 ();
  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus1 ();
  fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus2 ();

  fp_mul_seq #(.EXP_W(8), .MAN_W(23), .ROUND(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  fp_mul_seq #(.EXP_W(8), .MAN_W(23), .ROUND(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  fp_mul_seq #(.EXP_W(5), .MAN_W(10), .ROUND(1)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [34:0] val;
    longint      due;
  } exp_t;

  exp_t        sb   [3][$];
  logic [34:0] held [3];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // Result as {invalid, underflow, overflow, ans} from plain integer arithmetic.
  function automatic logic [34:0] ref_mul(input int ew, input int mw, input bit rnd,
                                          input logic [31:0] a, input logic [31:0] b);
    longint maxe = (longint'(1) << ew) - 1;
    longint bias = (longint'(1) << (ew - 1)) - 1;
    longint one  = longint'(1) << mw;
    longint ea   = (longint'(a) >> mw) & maxe;
    longint eb   = (longint'(b) >> mw) & maxe;
    longint ma   = longint'(a) & (one - 1);
    longint mb   = longint'(b) & (one - 1);
    longint sgn  = ((longint'(a) >> (ew + mw)) ^ (longint'(b) >> (ew + mw))) & 1;
    longint p, q, rem, half, e;
    int     sh;
    bit     nan  = (ea == maxe && ma != 0) || (eb == maxe && mb != 0);
    bit     infa = (ea == maxe && ma == 0);
    bit     infb = (eb == maxe && mb == 0);
    if (nan || (infa && eb == 0) || (infb && ea == 0))
      return {3'b100, 32'((maxe << mw) | (one >> 1))};
    if (infa || infb) return {3'b000, 32'((sgn << (ew + mw)) | (maxe << mw))};
    if (ea == 0 || eb == 0) return {3'b000, 32'(sgn << (ew + mw))};
    p  = (ma + one) * (mb + one);
    e  = ea + eb - bias;
    sh = mw;
    if (p >= (longint'(1) << (2 * mw + 1))) begin
      sh = mw + 1;
      e++;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q++;
    if (q == 2 * one) begin
      q = one;
      e++;
    end
    if (e >= maxe) return {3'b001, 32'((sgn << (ew + mw)) | (maxe << mw))};
    if (e <= 0) return {3'b010, 32'(sgn << (ew + mw))};
    return {3'b000, 32'((sgn << (ew + mw)) | (e << mw) | (q - one))};
  endfunction

  function automatic logic [31:0] rnd_op(input int ew, input int mw);
    longint maxe = (longint'(1) << ew) - 1;
    longint bias = (longint'(1) << (ew - 1)) - 1;
    longint e, m, s;
    case ($urandom_range(0, 7))
      0:       e = 0;
      1:       e = maxe;
      2:       e = longint'($urandom_range(1, 4));
      3:       e = maxe - longint'($urandom_range(1, 4));
      default: e = bias - 6 + longint'($urandom_range(0, 12));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 0 : (longint'($urandom) & ((longint'(1) << mw) - 1));
    s = longint'($urandom_range(0, 1));
    return 32'((s << (ew + mw)) | (e << mw) | m);
  endfunction

  task automatic cmp(input int id, input logic dn, input logic bz, input logic [34:0] act);
    exp_t it;
    if (dn) begin
      chk($sformatf("busy_at_done%0d", id), 64'(bz), 64'd0);
      if (sb[id].size() == 0) begin
        checks++;
        $display("FAIL spurious_done%0d: got done=1, expected no done at t=%0t", id, $time);
      end else begin
        it = sb[id].pop_front();
        chk($sformatf("result%0d", id), 64'(act), 64'(it.val));
        chk($sformatf("done_time%0d", id), 64'($time), 64'(it.due));
        held[id] = it.val;
      end
    end else begin
      chk($sformatf("hold%0d", id), 64'(act), 64'(held[id]));
      chk($sformatf("busy%0d", id), 64'(bz), 64'(sb[id].size() != 0));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) held[i] = '0;
    end else begin
      cmp(0, bus0.done, bus0.busy, {bus0.invalid, bus0.underflow, bus0.overflow, bus0.ans});
      cmp(1, bus1.done, bus1.busy, {bus1.invalid, bus1.underflow, bus1.overflow, bus1.ans});
      cmp(2, bus2.done, bus2.busy, {bus2.invalid, bus2.underflow, bus2.overflow, 16'h0000, bus2.ans});
    end
  end

  // Called just after a negedge; start is accepted at the following posedge.
  task automatic issue01(input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] e0, input logic [34:0] e1);
    exp_t it;
    bus0.a = a; bus0.b = b; bus1.a = a; bus1.b = b;
    bus0.start = 1'b1; bus1.start = 1'b1;
    @(posedge clk);
    it.due = longint'($time) + LAT0 * 10 + 5;
    it.val = e0; sb[0].push_back(it);
    it.val = e1; sb[1].push_back(it);
    #1;
    bus0.start = 1'b0; bus1.start = 1'b0;
    bus0.a = $urandom; bus0.b = $urandom; bus1.a = $urandom; bus1.b = $urandom;
  endtask

  task automatic wait01();
    bit ok = 1'b0;
    for (int i = 0; i < LAT0 + 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus0.done;
    end
    if (!ok) begin
      checks++;
      $display("FAIL timeout01: got no done within %0d cycles, expected done", LAT0 + 10);
      sb[0].delete(); sb[1].delete();
    end
  endtask

  task automatic issue2(input logic [15:0] a, input logic [15:0] b, input logic [34:0] e);
    exp_t it;
    bus2.a = a; bus2.b = b; bus2.start = 1'b1;
    @(posedge clk);
    it.due = longint'($time) + LAT2 * 10 + 5;
    it.val = e; sb[2].push_back(it);
    #1;
    bus2.start = 1'b0; bus2.a = 16'($urandom); bus2.b = 16'($urandom);
  endtask

  task automatic wait2();
    bit ok = 1'b0;
    for (int i = 0; i < LAT2 + 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus2.done;
    end
    if (!ok) begin
      checks++;
      $display("FAIL timeout2: got no done within %0d cycles, expected done", LAT2 + 10);
      sb[2].delete();
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;

    chk("model_exact",  64'(ref_mul(8, 23, 0, 32'h40200000, 32'h40200000)), 64'({3'b000, 32'h40C80000}));
    chk("model_trunc",  64'(ref_mul(8, 23, 0, 32'h3FC00001, 32'h3FC00000)), 64'({3'b000, 32'h40100000}));
    chk("model_rne",    64'(ref_mul(8, 23, 1, 32'h3FC00001, 32'h3FC00000)), 64'({3'b000, 32'h40100001}));
    chk("model_ovf",    64'(ref_mul(8, 23, 1, 32'h7F000000, 32'h40000000)), 64'({3'b001, 32'h7F800000}));
    chk("model_unf",    64'(ref_mul(8, 23, 1, 32'h00800000, 32'h3F000000)), 64'({3'b010, 32'h00000000}));
    chk("model_nan",    64'(ref_mul(8, 23, 1, 32'h7F800000, 32'h00000000)), 64'({3'b100, 32'h7FC00000}));
    chk("model_half",   64'(ref_mul(5, 10, 1, 32'h00003E00, 32'h00004000)), 64'({3'b000, 32'h00004200}));

    repeat (2) @(negedge clk);
    chk("reset_state0", 64'({bus0.done, bus0.busy, bus0.invalid, bus0.underflow, bus0.overflow, bus0.ans}), 64'd0);
    chk("reset_state2", 64'({bus2.done, bus2.busy, bus2.invalid, bus2.underflow, bus2.overflow, bus2.ans}), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Directed vectors; each follow-up start lands in the previous done cycle.
    issue01(32'h40200000, 32'h40200000, {3'b000, 32'h40C80000}, {3'b000, 32'h40C80000}); wait01();
    issue01(32'hC0200000, 32'h40000000, {3'b000, 32'hC0A00000}, {3'b000, 32'hC0A00000}); wait01();
    issue01(32'h3FC00001, 32'h3FC00000, {3'b000, 32'h40100000}, {3'b000, 32'h40100001}); wait01();
    issue01(32'h7F000000, 32'h40000000, {3'b001, 32'h7F800000}, {3'b001, 32'h7F800000}); wait01();
    issue01(32'h00800000, 32'h3F000000, {3'b010, 32'h00000000}, {3'b010, 32'h00000000}); wait01();
    issue01(32'h7F800000, 32'h00000000, {3'b100, 32'h7FC00000}, {3'b100, 32'h7FC00000}); wait01();
    issue01(32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000}, {3'b000, 32'hFF800000}); wait01();
    issue01(32'h80000000, 32'h40400000, {3'b000, 32'h80000000}, {3'b000, 32'h80000000}); wait01();
    repeat (3) @(negedge clk);

    // Starts pulsed mid-operation must be ignored.
    issue01(32'h40400000, 32'h40400000, {3'b000, 32'h41100000}, {3'b000, 32'h41100000});
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      bus0.start = (c == 5 || c == 20);
      bus1.start = (c == 5 || c == 20);
      bus0.a = 32'h3F800000; bus0.b = 32'h3F800000;
      bus1.a = 32'h3F800000; bus1.b = 32'h3F800000;
    end
    bus0.start = 1'b0; bus1.start = 1'b0;
    wait01();
    repeat (30) @(negedge clk);

    // Reset mid-operation aborts without a done; a fresh start then completes.
    issue01(32'h40200000, 32'h40200000, {3'b000, 32'h40C80000}, {3'b000, 32'h40C80000});
    repeat (9) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    sb[0].delete(); sb[1].delete(); sb[2].delete();
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus0.busy), 64'd0);
    chk("abort_ans",  64'(bus0.ans), 64'd0);
    issue01(32'hC0200000, 32'h40000000, {3'b000, 32'hC0A00000}, {3'b000, 32'hC0A00000}); wait01();

    for (int n = 0; n < 40; n++) begin
      ra = rnd_op(8, 23);
      rb = rnd_op(8, 23);
      issue01(ra, rb, ref_mul(8, 23, 0, ra, rb), ref_mul(8, 23, 1, ra, rb));
      wait01();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    issue2(16'h3E00, 16'h4000, {3'b000, 32'h00004200}); wait2();
    for (int n = 0; n < 30; n++) begin
      ra = rnd_op(5, 10);
      rb = rnd_op(5, 10);
      issue2(ra[15:0], rb[15:0], ref_mul(5, 10, 1, ra, rb));
      wait2();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
